alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, request valid.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 The block SHALL have port in_a, input, XLEN, operand A.
REQ-007 The block SHALL have port in_b, input, XLEN, operand B; for shifts only in_b[4:0] is used as shift amount.
REQ-008 The block SHALL have port in_op, input, 3, opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra.
REQ-009 The block SHALL have port out_valid, output, 1, result valid.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 The block SHALL have port out_result, output, XLEN, result.
REQ-012 The block SHALL have port out_illegal, output, 1, qualifies out_result; high when the op was not executed.

Function
REQ-013 A request SHALL be accepted on a cycle where in_valid and in_ready are both high; operands and op are captured on that edge.
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE; in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-015 Ops 0-4 SHALL go IDLE->DONE, out_valid high the cycle after acceptance (latency 1).
REQ-016 Ops 5-7 SHALL go IDLE->SHIFT; one bit position per cycle; SHIFT->DONE when remaining count reaches 0; latency = shamt+1 cycles; shamt 0 goes directly to DONE (latency 1).
REQ-017 add/sub SHALL wrap modulo 2^XLEN with no overflow flag; sll/srl fill zeros; sra replicates the captured in_a[XLEN-1].
REQ-018 In DONE, out_valid, out_result, out_illegal SHALL remain stable until out_valid and out_ready both high.
REQ-019 In DONE with out_ready high and in_valid high, result retires and new request is accepted on the same edge (back-to-back, one result per cycle for ops 0-4).
REQ-020 In DONE with out_ready high and no new request, state SHALL return to IDLE.
REQ-021 in_valid asserted during SHIFT SHALL be ignored (in_ready low); requester holds.

Reset
REQ-022 On rst high at a clock edge: state IDLE, out_valid 0, out_result 0, out_illegal 0, shift count 0; in_ready reads 1 the following cycle.
REQ-023 Reset during SHIFT or DONE SHALL abandon the operation; no partial result is ever presented.

Configuration
REQ-024 Macro ALU_EXEC_SHIFT_EN: when defined, ops 5-7 SHALL behave per REQ-016/017.
REQ-025 When ALU_EXEC_SHIFT_EN is undefined, ops 5-7 SHALL complete with latency 1, out_result 0, out_illegal 1; SHIFT state and counter are not built.

Structure
REQ-026 A shared package alu_pkg SHALL hold XLEN default and op constants ALU_ADD..ALU_SRA (3-bit).
REQ-027 Ops 0-4 SHALL be computed by instantiating the existing combinational alu sub-module (a, b, op, out); alu_exec adds only FSM, registers and shifter.

Verification
REQ-028 Reset then a=5,b=3,op=0, out_ready=1 -> out_valid 1 cycle later, result 8, illegal 0.
REQ-029 a=0,b=1,op=1 -> result 32'hFFFF_FFFF (wrap); a=32'hFFFF_FFFF,b=1,op=0 -> 0.
REQ-030 SHIFT_EN: a=32'h8000_0000,b=4,op=7 -> out_valid after 5 cycles, result 32'hF800_0000; in_ready low cycles 1-4; b=0,op=5 -> latency 1, result = a.
REQ-031 Backpressure: out_ready=0 for 3 cycles after result of a=6,b=3,op=2 -> result 2 held stable, in_ready low; out_ready=1 with next request op=3 a=4,b=1 -> next cycle result 5.
REQ-032 rst asserted mid-shift (a=1,b=31,op=5, after 10 cycles) -> next cycle out_valid 0, IDLE, no result delivered.
REQ-033 Without SHIFT_EN: op=6 -> latency 1, result 0, out_illegal 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute slice: default width, opcodes,
// FSM state encoding and a small opcode-class helper.
package alu_pkg;

    localparam int ALU_XLEN = 32;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU for the single-cycle ops (add/sub/and/or/xor).
// Shift opcodes produce 0 here; shifts are handled by alu_exec.
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    output logic [XLEN-1:0] out
);

    always_comb begin
        out = '0;
        case (op)
            ALU_ADD: out = a + b;
            ALU_SUB: out = a - b;
            ALU_AND: out = a & b;
            ALU_OR:  out = a | b;
            ALU_XOR: out = a ^ b;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: valid/ready request in, registered result out, with a
// bit-serial shifter built only when ALU_EXEC_SHIFT_EN is defined.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [2:0]      in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; out_* hold steady while out_valid is high and out_ready low.
    state_t            r_state;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_result;
    logic              r_illegal;
    logic [XLEN-1:0]   w_alu_out;
    logic              w_accept;

    alu #(.XLEN(XLEN)) u_alu (
        .a   (in_a),
        .b   (in_b),
        .op  (in_op),
        .out (w_alu_out)
    );

    assign in_ready    = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept    = in_valid && in_ready;
    assign out_valid   = r_out_valid;
    assign out_result  = r_result;
    assign out_illegal = r_illegal;

`ifdef ALU_EXEC_SHIFT_EN
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_sh;
    logic [2:0]      r_op;
    logic [XLEN-1:0] w_sh_next;

    // One bit position per cycle; sra keeps re-copying the captured sign bit.
    always_comb begin
        w_sh_next = '0;
        case (r_op)
            ALU_SLL: w_sh_next = {r_sh[XLEN-2:0], 1'b0};
            ALU_SRL: w_sh_next = {1'b0, r_sh[XLEN-1:1]};
            default: w_sh_next = {r_sh[XLEN-1], r_sh[XLEN-1:1]};
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_illegal   <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
            r_cnt       <= '0;
            r_sh        <= '0;
            r_op        <= ALU_ADD;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        if (is_shift_op(in_op)) begin
`ifdef ALU_EXEC_SHIFT_EN
                            if (in_b[4:0] == 5'd0) begin
                                r_state     <= ST_DONE;
                                r_out_valid <= 1'b1;
                                r_result    <= in_a;
                                r_illegal   <= 1'b0;
                            end else begin
                                r_state     <= ST_SHIFT;
                                r_out_valid <= 1'b0;
                                r_sh        <= in_a;
                                r_cnt       <= in_b[4:0];
                                r_op        <= in_op;
                            end
`else
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= '0;
                            r_illegal   <= 1'b1;
`endif
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_alu_out;
                            r_illegal   <= 1'b0;
                        end
                    end else if ((r_state == ST_DONE) && out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
`ifdef ALU_EXEC_SHIFT_EN
                ST_SHIFT: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_sh_next;
                        r_illegal   <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: driver pushes expected {illegal,result} and
// retire edge into queues, an independent monitor pops them on each transfer.
module tb_alu_exec;
    import alu_pkg::*;

    localparam int XLEN = 32;
    localparam int W    = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [2:0]      in_op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_illegal;

    logic [W-1:0] exp_q[$];
    int           ret_q[$];
    int           cyc       = 0;
    int           checks    = 0;
    int           errors    = 0;
    int           n_pushed  = 0;
    int           n_retired = 0;

    alu_exec #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_illegal (out_illegal)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver: present request, wait for acceptance, record expectation
    task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [2:0] op, input logic [XLEN-1:0] res,
                         input logic ill, input int lat, input bit push);
        bit rdy;
        int e;
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        rdy      = 1'b0;
        e        = 0;
        n        = 0;
        while (!rdy && n < 100) begin
            @(negedge clk);
            rdy = in_ready;
            e   = cyc + 1;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no acceptance expected acceptance within 100 cycles");
        end else if (push) begin
            exp_q.push_back({ill, res});
            ret_q.push_back(e + lat);
            n_pushed++;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        int           r;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected no output", out_result);
            end else begin
                e = exp_q.pop_front();
                r = ret_q.pop_front();
                chk("result", {32'd0, out_result}, {32'd0, e[XLEN-1:0]});
                chk("illegal", {63'd0, out_illegal}, {63'd0, e[XLEN]});
                chk("retire_cycle", 64'(cyc + 1), 64'(r));
                n_retired++;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = ALU_ADD;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_result", {32'd0, out_result}, 64'd0);
        chk("reset_out_illegal", {63'd0, out_illegal}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // single-cycle ops, back-to-back
        issue(32'd5, 32'd3, ALU_ADD, 32'd8, 1'b0, 1, 1'b1);
        issue(32'd0, 32'd1, ALU_SUB, 32'hFFFF_FFFF, 1'b0, 1, 1'b1);
        issue(32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'd0, 1'b0, 1, 1'b1);
        issue(32'h0000_F0F0, 32'h0000_0FF0, ALU_AND, 32'h0000_00F0, 1'b0, 1, 1'b1);
        issue(32'h0000_F0F0, 32'h0000_0FF0, ALU_OR,  32'h0000_FFF0, 1'b0, 1, 1'b1);
        issue(32'h0000_F0F0, 32'h0000_0FF0, ALU_XOR, 32'h0000_FF00, 1'b0, 1, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #1;

`ifdef ALU_EXEC_SHIFT_EN
        issue(32'h8000_0000, 32'd4, ALU_SRA, 32'hF800_0000, 1'b0, 5, 1'b1);
        idle();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("shift_in_ready_low", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        issue(32'h1234_5678, 32'd0, ALU_SLL, 32'h1234_5678, 1'b0, 1, 1'b1);
        issue(32'h8000_0001, 32'd3, ALU_SRL, 32'h1000_0000, 1'b0, 4, 1'b1);
        issue(32'h4000_0000, 32'd2, ALU_SRA, 32'h1000_0000, 1'b0, 3, 1'b1);
        issue(32'h0000_0003, 32'h0000_FFFF, ALU_SLL, 32'h8000_0000, 1'b0, 32, 1'b1);
        issue(32'd7, 32'd9, ALU_ADD, 32'd16, 1'b0, 1, 1'b1);
`else
        issue(32'h8000_0000, 32'd4, ALU_SRL, 32'd0, 1'b1, 1, 1'b1);
        issue(32'h1234_5678, 32'd1, ALU_SLL, 32'd0, 1'b1, 1, 1'b1);
        issue(32'h8000_0000, 32'd4, ALU_SRA, 32'd0, 1'b1, 1, 1'b1);
        issue(32'd7, 32'd9, ALU_ADD, 32'd16, 1'b0, 1, 1'b1);
`endif
        idle();
        repeat (2) @(posedge clk);
        #1;

        // backpressure: result held for 3 cycles, then retire with next request
        out_ready = 1'b0;
        issue(32'd6, 32'd3, ALU_AND, 32'd2, 1'b0, 4, 1'b1);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_out_result", {32'd0, out_result}, 64'd2);
            chk("hold_in_ready_low", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        issue(32'd4, 32'd1, ALU_OR, 32'd5, 1'b0, 1, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // reset while a result waits in DONE: it must be dropped
        out_ready = 1'b0;
        issue(32'd7, 32'd7, ALU_ADD, 32'd14, 1'b0, 1, 1'b0);
        idle();
        @(negedge clk);
        chk("done_before_reset_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("abort_done_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_done_out_result", {32'd0, out_result}, 64'd0);
        chk("abort_done_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

`ifdef ALU_EXEC_SHIFT_EN
        // reset mid-shift: nothing may ever be delivered for it
        issue(32'd1, 32'd31, ALU_SLL, 32'h8000_0000, 1'b0, 32, 1'b0);
        idle();
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_shift_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_shift_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (40) @(posedge clk);
        #1;
`endif
        issue(32'd2, 32'd2, ALU_ADD, 32'd4, 1'b0, 1, 1'b1);
        idle();

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("retired_count", 64'(n_retired), 64'(n_pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
